// File: rtl/tape_pkg.sv
// Shared G-15 tape definitions: punch state encoding, frame layout and
// default mechanical timing used by both the punch and the reader.
package tape_pkg;

  typedef enum logic [1:0] {
    PS_IDLE     = 2'd0,
    PS_ENERGIZE = 2'd1,
    PS_DELIVER  = 2'd2,
    PS_RECOVER  = 2'd3
  } punch_state_t;

  localparam int PUNCH_FRAME_W = 6;
  localparam int FEED_FLAG_BIT = 5;
  localparam int PUNCH_CODE_W  = 5;
  localparam int PUNCH_CNT_W   = 8;

  localparam int unsigned T_ENERGIZE_MS_DEF = 40;
  localparam int unsigned T_RECOVER_MS_DEF  = 60;

  // Interval length in ticks; zero still costs one tick, large values saturate.
  function automatic logic [PUNCH_CNT_W-1:0] ms_to_count(input int unsigned ms);
    logic [PUNCH_CNT_W-1:0] cnt;
    if (ms == 32'd0) begin
      cnt = 8'd1;
    end else if (ms > 32'd255) begin
      cnt = 8'd255;
    end else begin
      cnt = ms[PUNCH_CNT_W-1:0];
    end
    return cnt;
  endfunction

  function automatic logic [PUNCH_FRAME_W-1:0] make_frame(
    input logic                    feed,
    input logic [PUNCH_CODE_W-1:0] code
  );
    logic [PUNCH_FRAME_W-1:0] frame;
    frame                = '0;
    frame[PUNCH_CODE_W-1:0] = code;
    frame[FEED_FLAG_BIT] = feed;
    return frame;
  endfunction

endpackage

// File: rtl/tape_punch.sv
// G-15 paper-tape punch: paces each 5-bit frame through energize/recover
// intervals on the 1 ms tick and hands punched frames to a host sink.
module tape_punch
  import tape_pkg::*;
#(
  parameter int unsigned T_ENERGIZE_MS = T_ENERGIZE_MS_DEF,
  parameter int unsigned T_RECOVER_MS  = T_RECOVER_MS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_ms,
  input  logic                     PUNCH_CMD,
  input  logic [PUNCH_CODE_W-1:0]  PUNCH_CODE,
  input  logic                     SW_TAPE_FEED,
  output logic                     PUNCH_BUSY,
  output logic                     PUNCH_OVERRUN,
  output logic                     frame_valid,
  output logic [PUNCH_FRAME_W-1:0] frame_data,
  input  logic                     frame_ready
);

  localparam logic [PUNCH_CNT_W-1:0] C_ENERGIZE_CNT = ms_to_count(T_ENERGIZE_MS);
  localparam logic [PUNCH_CNT_W-1:0] C_RECOVER_CNT  = ms_to_count(T_RECOVER_MS);

  punch_state_t             r_state;
  logic [PUNCH_CNT_W-1:0]   r_cnt;
  logic                     r_cmd_d;
  logic [PUNCH_FRAME_W-1:0] r_latch;
  logic                     r_busy;
  logic                     r_overrun;
  logic                     r_valid;
  logic [PUNCH_FRAME_W-1:0] r_data;

  punch_state_t             w_state_nxt;
  logic [PUNCH_CNT_W-1:0]   w_cnt_nxt;
  logic [PUNCH_FRAME_W-1:0] w_latch_nxt;
  logic                     w_overrun_nxt;
  logic                     w_cmd_rise;
  logic                     w_tick_last;
  logic                     w_handshake;

  assign w_cmd_rise  = PUNCH_CMD & ~r_cmd_d;
  assign w_tick_last = tick_ms & (r_cnt <= 8'd1);
  assign w_handshake = r_valid & frame_ready;

  // Next-state, interval counter and frame latch; edges while busy are dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_latch_nxt   = r_latch;
    w_overrun_nxt = r_overrun | (w_cmd_rise & (r_state != PS_IDLE));

    case (r_state)
      PS_IDLE: begin
        if (w_cmd_rise) begin
          w_latch_nxt = make_frame(1'b0, PUNCH_CODE);
          w_cnt_nxt   = C_ENERGIZE_CNT;
          w_state_nxt = PS_ENERGIZE;
        end else if (SW_TAPE_FEED) begin
          w_latch_nxt = make_frame(1'b1, 5'd0);
          w_cnt_nxt   = C_ENERGIZE_CNT;
          w_state_nxt = PS_ENERGIZE;
        end else begin
          w_state_nxt = PS_IDLE;
        end
      end

      PS_ENERGIZE: begin
        if (w_tick_last) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = PS_DELIVER;
        end else if (tick_ms) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end

      PS_DELIVER: begin
        if (w_handshake) begin
          w_cnt_nxt   = C_RECOVER_CNT;
          w_state_nxt = PS_RECOVER;
        end else begin
          w_state_nxt = PS_DELIVER;
        end
      end

      PS_RECOVER: begin
        // Returning through IDLE lets a held feed switch start the next frame.
        if (w_tick_last) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = PS_IDLE;
        end else if (tick_ms) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end

      default: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = PS_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PS_IDLE;
      r_cnt     <= 8'd0;
      r_cmd_d   <= 1'b0;
      r_latch   <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cmd_d   <= PUNCH_CMD;
      r_latch   <= w_latch_nxt;
      r_busy    <= (w_state_nxt != PS_IDLE);
      r_overrun <= w_overrun_nxt;
      r_valid   <= (w_state_nxt == PS_DELIVER);
      r_data    <= (w_state_nxt == PS_DELIVER) ? w_latch_nxt : '0;
    end
  end

  assign PUNCH_BUSY    = r_busy;
  assign PUNCH_OVERRUN = r_overrun;
  assign frame_valid   = r_valid;
  assign frame_data    = r_data;

endmodule

// File: tb/tb_tape_punch.sv
// Directed bench for tape_punch: phase table timed in 1 ms ticks plus
// hand sequences for continuous tape feed and reset with command held.
module tb_tape_punch;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_ms;
  logic       cmd;
  logic [4:0] code;
  logic       feed;
  logic       ready;
  logic       busy;
  logic       ovr;
  logic       valid;
  logic [5:0] data;

  always #5 clk = ~clk;

  // Fast stand-in for the timer block: one tick every 10 clocks.
  logic [3:0] tdiv = 4'd0;
  int         tick_cnt = 0;
  always @(posedge clk) tdiv <= (tdiv == 4'd9) ? 4'd0 : tdiv + 4'd1;
  assign tick_ms = (tdiv == 4'd9);
  always @(posedge clk) if (tick_ms) tick_cnt <= tick_cnt + 1;

  tape_punch dut (
    .clk          (clk),
    .rst          (rst),
    .tick_ms      (tick_ms),
    .PUNCH_CMD    (cmd),
    .PUNCH_CODE   (code),
    .SW_TAPE_FEED (feed),
    .PUNCH_BUSY   (busy),
    .PUNCH_OVERRUN(ovr),
    .frame_valid  (valid),
    .frame_data   (data),
    .frame_ready  (ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frames delivered while the feed monitor is enabled.
  logic       mon_en = 1'b0;
  int         feed_n = 0;
  int         feed_stamp [8];
  logic [5:0] feed_dat [8];
  always @(posedge clk) begin
    if (mon_en && valid && ready && feed_n < 8) begin
      feed_stamp[feed_n] <= tick_cnt;
      feed_dat[feed_n]   <= data;
      feed_n             <= feed_n + 1;
    end
  end

  typedef struct {
    string      name;
    logic       rst;
    logic       cmd;
    logic [4:0] code;
    logic       feed;
    logic       ready;
    int         ticks;
    int         cycles;
    logic       e_busy;
    logic       e_ovr;
    logic       e_valid;
    logic [5:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic c, input logic [4:0] cd,
                     input logic f, input logic rd, input int tk, input int cy,
                     input logic eb, input logic eo, input logic ev, input logic [5:0] ed);
    vec_t v;
    v.name = nm; v.rst = r; v.cmd = c; v.code = cd; v.feed = f; v.ready = rd;
    v.ticks = tk; v.cycles = cy;
    v.e_busy = eb; v.e_ovr = eo; v.e_valid = ev; v.e_data = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tick_cnt;
    while (tick_cnt - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; cmd = 1'b0; code = 5'h00; feed = 1'b0; ready = 1'b1;

    //   name            rst cmd code  fd rdy ticks cyc busy ovr vld data
    add("reset",         1, 0, 5'h00, 0, 1,  0, 3,  0, 0, 0, 6'h00);
    add("idle_10",       0, 0, 5'h00, 0, 1, 10, 0,  0, 0, 0, 6'h00);
    add("accept",        0, 1, 5'h13, 0, 1,  0, 1,  1, 0, 0, 6'h00);
    add("energize_39",   0, 0, 5'h0A, 0, 1, 39, 0,  1, 0, 0, 6'h00);
    add("deliver",       0, 0, 5'h0A, 0, 1,  1, 0,  1, 0, 1, 6'h13);
    add("handshake",     0, 0, 5'h0A, 0, 1,  0, 1,  1, 0, 0, 6'h00);
    add("recover_59",    0, 0, 5'h0A, 0, 1, 59, 0,  1, 0, 0, 6'h00);
    add("recover_done",  0, 0, 5'h0A, 0, 1,  1, 0,  0, 0, 0, 6'h00);
    add("bp_accept",     0, 1, 5'h13, 0, 0,  0, 1,  1, 0, 0, 6'h00);
    add("bp_valid",      0, 0, 5'h0A, 0, 0, 40, 0,  1, 0, 1, 6'h13);
    add("bp_hold_25",    0, 0, 5'h0A, 0, 0, 25, 0,  1, 0, 1, 6'h13);
    add("bp_handshake",  0, 0, 5'h0A, 0, 1,  0, 1,  1, 0, 0, 6'h00);
    add("bp_recover_59", 0, 0, 5'h0A, 0, 1, 59, 0,  1, 0, 0, 6'h00);
    add("bp_done",       0, 0, 5'h0A, 0, 1,  1, 0,  0, 0, 0, 6'h00);
    add("ov_accept",     0, 1, 5'h13, 0, 1,  0, 1,  1, 0, 0, 6'h00);
    add("ov_energize",   0, 0, 5'h0A, 0, 1, 20, 0,  1, 0, 0, 6'h00);
    add("ov_edge",       0, 1, 5'h07, 0, 1,  0, 1,  1, 1, 0, 6'h00);
    add("ov_deliver",    0, 0, 5'h07, 0, 1, 20, 0,  1, 1, 1, 6'h13);
    add("ov_handshake",  0, 0, 5'h07, 0, 1,  0, 1,  1, 1, 0, 6'h00);
    add("ov_recover",    0, 0, 5'h07, 0, 1, 60, 0,  0, 1, 0, 6'h00);
    add("ov_no_queue",   0, 0, 5'h07, 0, 1,  0, 5,  0, 1, 0, 6'h00);
    add("rm_accept",     0, 1, 5'h15, 0, 1,  0, 1,  1, 1, 0, 6'h00);
    add("rm_energize",   0, 0, 5'h0A, 0, 1, 30, 0,  1, 1, 0, 6'h00);
    add("rm_reset",      1, 0, 5'h0A, 0, 1,  0, 1,  0, 0, 0, 6'h00);
    add("rm_dropped",    0, 0, 5'h0A, 0, 1, 15, 0,  0, 0, 0, 6'h00);
    add("rm_accept2",    0, 1, 5'h15, 0, 1,  0, 1,  1, 0, 0, 6'h00);
    add("rm_deliver2",   0, 0, 5'h0A, 0, 1, 40, 0,  1, 0, 1, 6'h15);
    add("rm_handshake2", 0, 0, 5'h0A, 0, 1,  0, 1,  1, 0, 0, 6'h00);
    add("rm_done2",      0, 0, 5'h0A, 0, 1, 60, 0,  0, 0, 0, 6'h00);
    add("pr_both",       0, 1, 5'h1F, 1, 1,  0, 1,  1, 0, 0, 6'h00);
    add("pr_cmd_frame",  0, 0, 5'h0A, 1, 1, 40, 0,  1, 0, 1, 6'h1F);
    add("pr_handshake",  0, 0, 5'h0A, 1, 1,  0, 1,  1, 0, 0, 6'h00);
    add("pr_recover",    0, 0, 5'h0A, 1, 1, 60, 0,  0, 0, 0, 6'h00);
    add("pr_feed_start", 0, 0, 5'h0A, 1, 1,  0, 1,  1, 0, 0, 6'h00);
    add("pr_feed_frame", 0, 0, 5'h0A, 1, 1, 40, 0,  1, 0, 1, 6'h20);
    add("pr_feed_hs",    0, 0, 5'h0A, 0, 1,  0, 1,  1, 0, 0, 6'h00);
    add("pr_feed_done",  0, 0, 5'h0A, 0, 1, 60, 0,  0, 0, 0, 6'h00);
    add("pr_quiet",      0, 0, 5'h0A, 0, 1,  0, 3,  0, 0, 0, 6'h00);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; cmd = vecs[i].cmd; code = vecs[i].code;
      feed = vecs[i].feed; ready = vecs[i].ready;
      wait_ticks(vecs[i].ticks);
      wait_cycles(vecs[i].cycles);
      chk({vecs[i].name, ".busy"},    int'(busy),  int'(vecs[i].e_busy));
      chk({vecs[i].name, ".overrun"}, int'(ovr),   int'(vecs[i].e_ovr));
      chk({vecs[i].name, ".valid"},   int'(valid), int'(vecs[i].e_valid));
      if (vecs[i].e_valid || vecs[i].rst)
        chk({vecs[i].name, ".data"}, int'(data), int'(vecs[i].e_data));
    end

    // Feed switch held 350 ms: four blank feed frames, 100 ms apart.
    mon_en = 1'b1;
    feed   = 1'b1;
    wait_ticks(350);
    feed = 1'b0;
    wait_ticks(200);
    mon_en = 1'b0;
    chk("feed.count", feed_n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("feed.data%0d", i), int'(feed_dat[i]), 32'h20);
    for (int i = 0; i < 3; i++)
      chk($sformatf("feed.spacing%0d", i), feed_stamp[i+1] - feed_stamp[i], 100);
    chk("feed.idle_after", int'(busy), 0);

    // Command already high when reset releases counts as a rising edge.
    rst = 1'b1; cmd = 1'b1; code = 5'h0C;
    wait_cycles(3);
    chk("rstcmd.held_busy", int'(busy), 0);
    rst = 1'b0;
    wait_cycles(1);
    chk("rstcmd.release_busy", int'(busy), 1);
    cmd = 1'b0;
    wait_ticks(40);
    chk("rstcmd.valid", int'(valid), 1);
    chk("rstcmd.data", int'(data), 32'h0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
